// File: rtl/smp_timer_unit.sv
// SMP I/O-page timers: two 8 kHz timers (T0, T1) and one 64 kHz timer (T2).
// Each timer has an 8-bit stage-2 divider and a 4-bit output counter that clears when read.
// Bus handshake: an access is qualified only by CE=1. WE_N=0 means write; WE_N=1 with
// ADDR in $00FD..$00FF means read. There is no back-pressure.
module smp_timer_unit #(
  parameter int T01_DIV = 128,
  parameter int T2_DIV  = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE,
  input  logic [15:0] ADDR,
  input  logic [7:0]  DI,
  input  logic        WE_N,
  output logic [7:0]  DO,
  output logic        DO_HIT,
  output logic [2:0]  TIMER_EN
);

  localparam int PW = (T01_DIV > 1) ? $clog2(T01_DIV) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(T01_DIV - 1);
  localparam logic [PW-1:0] P2_MASK = PW'(T2_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    en_q, en_d;
  logic [7:0]    stage_q [3];
  logic [7:0]    stage_d [3];
  logic [7:0]    div_q   [3];
  logic [7:0]    div_d   [3];
  logic [3:0]    out_q   [3];
  logic [3:0]    out_d   [3];
  logic [7:0]    nxt     [3];

  logic       wr, rd, ctrl_wr, tick01, tick2;
  logic [2:0] tick, div_wr, rd_sel, en_rise;

  assign wr      = CE & ~WE_N;
  assign DO_HIT  = (ADDR == 16'h00FD) || (ADDR == 16'h00FE) || (ADDR == 16'h00FF);
  assign rd      = CE & WE_N & DO_HIT;
  assign ctrl_wr = wr && (ADDR == 16'h00F1);

  assign tick01 = CE && (presc_q == P_LAST);
  assign tick2  = CE && ((presc_q & P2_MASK) == P2_MASK);
  assign tick   = {tick2, tick01, tick01};

  assign presc_d  = CE ? presc_q + PW'(1) : presc_q;
  assign en_d     = ctrl_wr ? DI[2:0] : en_q;
  assign en_rise  = ctrl_wr ? (DI[2:0] & ~en_q) : 3'b000;
  assign TIMER_EN = en_q;

  always_comb begin
    for (int n = 0; n < 3; n++) begin
      div_wr[n]  = wr && (ADDR == (16'h00FA + 16'(n)));
      rd_sel[n]  = rd && (ADDR == (16'h00FD + 16'(n)));
      nxt[n]     = stage_q[n] + 8'd1;
      div_d[n]   = div_wr[n] ? DI : div_q[n];
      stage_d[n] = stage_q[n];
      out_d[n]   = rd_sel[n] ? 4'h0 : out_q[n];
      if (en_rise[n]) begin
        // A fresh enable restarts the timer; no tick is counted in this cycle.
        stage_d[n] = 8'h00;
        out_d[n]   = 4'h0;
      end else if (en_q[n] && tick[n]) begin
        if (nxt[n] == div_q[n]) begin
          stage_d[n] = 8'h00;
          // A coincident read still keeps this increment.
          out_d[n]   = rd_sel[n] ? 4'h1 : out_q[n] + 4'h1;
        end else begin
          stage_d[n] = nxt[n];
        end
      end
    end
  end

  always_comb begin
    DO = 8'h00;
    case (ADDR)
      16'h00FD: DO = {4'h0, out_q[0]};
      16'h00FE: DO = {4'h0, out_q[1]};
      16'h00FF: DO = {4'h0, out_q[2]};
      default:  DO = 8'h00;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      presc_q <= '0;
      en_q    <= 3'b000;
      for (int n = 0; n < 3; n++) begin
        stage_q[n] <= 8'h00;
        div_q[n]   <= 8'h00;
        out_q[n]   <= 4'h0;
      end
    end else begin
      presc_q <= presc_d;
      en_q    <= en_d;
      for (int n = 0; n < 3; n++) begin
        stage_q[n] <= stage_d[n];
        div_q[n]   <= div_d[n];
        out_q[n]   <= out_d[n];
      end
    end
  end

endmodule

// File: tb/tb_smp_timer_unit.sv
// Directed bench for smp_timer_unit: read expectations go into a queue, and a negedge
// monitor checks them against DO whenever a qualified read is on the bus.
module tb_smp_timer_unit;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CE = 1'b0;
  logic [15:0] ADDR = 16'h0000;
  logic [7:0]  DI = 8'h00;
  logic        WE_N = 1'b1;
  logic [7:0]  DO;
  logic        DO_HIT;
  logic [2:0]  TIMER_EN;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  smp_timer_unit dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .ADDR(ADDR), .DI(DI), .WE_N(WE_N),
    .DO(DO), .DO_HIT(DO_HIT), .TIMER_EN(TIMER_EN)
  );

  always #5 CLK = ~CLK;

  // Monitor: every qualified read must match the oldest expectation.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST_N && CE && WE_N && DO_HIT) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_read addr=%h DO=%h", ADDR, DO);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (DO !== e) begin
            fails++;
            $display("FAIL read_%h got=%h exp=%h t=%0t", ADDR, DO, e, $time);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0; CE = 1'b0; WE_N = 1'b1; ADDR = 16'h0000;
    cyc(); cyc();
    RST_N = 1'b1;
  endtask

  task automatic idle(input int n);
    CE = 1'b1; WE_N = 1'b1; ADDR = 16'h0000;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    CE = 1'b1; WE_N = 1'b0; ADDR = a; DI = d;
    cyc();
    WE_N = 1'b1; ADDR = 16'h0000;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e);
    exp_q.push_back(e);
    CE = 1'b1; WE_N = 1'b1; ADDR = a;
    cyc();
    ADDR = 16'h0000;
  endtask

  initial begin
    // Reset values and address decode
    do_reset();
    ADDR = 16'h00F1; #1;
    chk("hit_f1", {7'd0, DO_HIT}, 8'h00);
    chk("do_f1", DO, 8'h00);
    ADDR = 16'h00FD; #1;
    chk("hit_fd", {7'd0, DO_HIT}, 8'h01);
    chk("do_fd_reset", DO, 8'h00);
    chk("en_reset", {5'd0, TIMER_EN}, 8'h00);

    // 1: T0 div 2, 256 CE -> two ticks -> one output count
    do_reset();
    wr(16'h00F1, 8'h01);
    chk("en_t0", {5'd0, TIMER_EN}, 8'h01);
    wr(16'h00FA, 8'h02);
    idle(256);
    rd(16'h00FD, 8'h01);
    rd(16'h00FD, 8'h00);

    // 2: T2 div 0 means 256 ticks; no early match on the second pass
    do_reset();
    wr(16'h00FC, 8'h00);
    wr(16'h00F1, 8'h04);
    idle(16 * 256);
    rd(16'h00FF, 8'h01);
    idle(16 * 255);
    rd(16'h00FF, 8'h00);

    // 3: 17 counts wrap to 1; 1->1 keeps it, 0->1 clears it
    do_reset();
    wr(16'h00F1, 8'h01);
    wr(16'h00FA, 8'h01);
    idle(128 * 17);
    wr(16'h00F1, 8'h01);
    rd(16'h00FD, 8'h01);
    wr(16'h00F1, 8'h00);
    chk("en_off", {5'd0, TIMER_EN}, 8'h00);
    wr(16'h00F1, 8'h01);
    rd(16'h00FD, 8'h00);

    // 4: read on the increment tick with TnOUT=3; back-to-back reads
    do_reset();
    wr(16'h00F1, 8'h01);
    wr(16'h00FA, 8'h01);
    idle(509);
    rd(16'h00FD, 8'h03);
    rd(16'h00FD, 8'h01);

    // 5: retarget T1 below its stage2 -> match only after wrap; CE=0 freezes everything
    do_reset();
    wr(16'h00F1, 8'h02);
    idle(1279);
    wr(16'h00FB, 8'h05);
    idle(31999);
    rd(16'h00FE, 8'h00);
    idle(127);
    rd(16'h00FE, 8'h01);
    CE = 1'b0; WE_N = 1'b1; ADDR = 16'h00FE;
    for (int i = 0; i < 1000; i++) cyc();
    idle(638);
    rd(16'h00FE, 8'h00);
    idle(1);
    rd(16'h00FE, 8'h01);

    // 6: reset while all three run overrides a simultaneous write
    do_reset();
    wr(16'h00FA, 8'h01);
    wr(16'h00FB, 8'h01);
    wr(16'h00FC, 8'h01);
    wr(16'h00F1, 8'h07);
    chk("en_all", {5'd0, TIMER_EN}, 8'h07);
    idle(300);
    RST_N = 1'b0; CE = 1'b1; WE_N = 1'b0; ADDR = 16'h00F1; DI = 8'h07;
    cyc();
    RST_N = 1'b1; CE = 1'b0; WE_N = 1'b1; ADDR = 16'h00FF; #1;
    chk("en_after_rst", {5'd0, TIMER_EN}, 8'h00);
    chk("do_after_rst", DO, 8'h00);
    rd(16'h00FD, 8'h00);
    rd(16'h00FE, 8'h00);
    rd(16'h00FF, 8'h00);
    wr(16'h00F1, 8'h01);
    idle(300);
    rd(16'h00FD, 8'h00);

    idle(2);
    chk("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
